mc_control_fsm: RTL and testbench

//  Multi-cycle control sequencer for the MIPS-lite datapath; runs one instruction over 3-5+ cycles.

---
 rtl/mc_control_fsm_pkg.sv | 64 ++++++
 rtl/mc_control_fsm_op_class.sv | 22 ++
 rtl/mc_control_fsm.sv | 154 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, state codes,
// datapath select codes and the one-hot opcode class.
package mc_control_fsm_pkg;

  localparam int OP_W          = 6;
  localparam int ALU_OP_LENGTH = 2;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_JAL    = 6'b000011;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_WB_R   = 4'd4,
    ST_EXEC_I = 4'd5,
    ST_WB_I   = 4'd6,
    ST_ADDR   = 4'd7,
    ST_MEM_RD = 4'd8,
    ST_WB_MEM = 4'd9,
    ST_MEM_WR = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_B_RT      = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_OR    = 2'b10;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b11;

  typedef struct packed {
    logic r;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic bad;
  } op_class_t;

endpackage

// File: rtl/mc_control_fsm_op_class.sv
// Opcode classifier: maps the instruction opcode onto a one-hot class vector.
module mc_op_class
  import mc_control_fsm_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output op_class_t       o_class
);

  always_comb begin
    o_class     = '0;
    o_class.r   = (op == OP_W'(OP_R_TYPE));
    o_class.ori = (op == OP_W'(OP_ORI));
    o_class.lw  = (op == OP_W'(OP_LW));
    o_class.sw  = (op == OP_W'(OP_SW));
    o_class.beq = (op == OP_W'(OP_BEQ));
    o_class.jal = (op == OP_W'(OP_JAL));
    o_class.bad = ~(o_class.r | o_class.ori | o_class.lw | o_class.sw | o_class.beq | o_class.jal);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-lite datapath; one state register
// plus combinational next-state and control decode over a shared memory port.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = ALU_OP_LENGTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               extend_op,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               illegal
);

  state_t    r_state;
  state_t    w_state_next;
  op_class_t w_class;

  mc_op_class #(.OP_W(OP_W)) u_op_class (
    .op      (op),
    .o_class (w_class)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // zero is consumed by the datapath through pc_write_cond, not by the sequencer.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  always_comb begin
    w_state_next  = ST_IDLE;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_RT;
    alu_op        = ALUOP_W'(ALU_OP_ADD);
    extend_op     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = REG_DST_RT;
    mem_to_reg    = M2R_ALUOUT;
    illegal       = 1'b0;
    unique case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH: begin
        mem_req      = 1'b1;
        alu_src_b    = ALU_B_FOUR;
        // IR and PC+4 are committed only in the cycle the fetch completes.
        ir_write     = mem_ack;
        pc_write     = mem_ack;
        w_state_next = mem_ack ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        alu_src_b = ALU_B_IMM_SH2;
        extend_op = 1'b1;
        if      (w_class.r)                w_state_next = ST_EXEC_R;
        else if (w_class.ori)              w_state_next = ST_EXEC_I;
        else if (w_class.lw || w_class.sw) w_state_next = ST_ADDR;
        else if (w_class.beq)              w_state_next = ST_BRANCH;
        else if (w_class.jal)              w_state_next = ST_JUMP;
        else                               w_state_next = ST_TRAP;
      end
      ST_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_op       = ALUOP_W'(ALU_OP_FUNCT);
        w_state_next = ST_WB_R;
      end
      ST_WB_R: begin
        reg_write    = 1'b1;
        reg_dst      = REG_DST_RD;
        w_state_next = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = ALU_B_IMM;
        alu_op       = ALUOP_W'(ALU_OP_OR);
        w_state_next = ST_WB_I;
      end
      ST_WB_I: begin
        reg_write    = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        extend_op = 1'b1;
        // IR is stable here; anything but LW/SW would mean a corrupted decode.
        if      (w_class.lw) w_state_next = ST_MEM_RD;
        else if (w_class.sw) w_state_next = ST_MEM_WR;
        else                 w_state_next = ST_TRAP;
      end
      ST_MEM_RD: begin
        mem_req      = 1'b1;
        i_or_d       = 1'b1;
        w_state_next = mem_ack ? ST_WB_MEM : ST_MEM_RD;
      end
      ST_WB_MEM: begin
        reg_write    = 1'b1;
        mem_to_reg   = M2R_MDR;
        w_state_next = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        i_or_d       = 1'b1;
        w_state_next = mem_ack ? ST_FETCH : ST_MEM_WR;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALU_OP_SUB);
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
        w_state_next  = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write     = 1'b1;
        pc_src       = PC_SRC_JUMP;
        reg_write    = 1'b1;
        reg_dst      = REG_DST_RA;
        mem_to_reg   = M2R_PC;
        w_state_next = ST_FETCH;
      end
      ST_TRAP: begin
        illegal      = 1'b1;
        w_state_next = ST_TRAP;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the stimulus queues the expected control
// vector for every cycle, and a negedge monitor pops and compares it.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic       alu_src_a, extend_op, reg_write, illegal;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .extend_op(extend_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {req, we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src, a, b, alu_op, ext, reg_write, reg_dst, mem_to_reg, illegal}
  function automatic logic [19:0] mk(input logic req, we, iord, irw, pcw, pcwc,
                                     input logic [1:0] pcsrc, input logic a,
                                     input logic [1:0] b, aop, input logic ext, rw,
                                     input logic [1:0] rdst, m2r, input logic ill);
    return {req, we, iord, irw, pcw, pcwc, pcsrc, a, b, aop, ext, rw, rdst, m2r, ill};
  endfunction

  localparam logic [19:0] E_ZERO       = 20'h0;
  localparam logic [19:0] E_FETCH_WAIT = mk(1,0,0,0,0,0,2'd0,0,2'd1,2'd0,0,0,2'd0,2'd0,0);
  localparam logic [19:0] E_FETCH_ACK  = mk(1,0,0,1,1,0,2'd0,0,2'd1,2'd0,0,0,2'd0,2'd0,0);
  localparam logic [19:0] E_DECODE     = mk(0,0,0,0,0,0,2'd0,0,2'd3,2'd0,1,0,2'd0,2'd0,0);
  localparam logic [19:0] E_EXEC_R     = mk(0,0,0,0,0,0,2'd0,1,2'd0,2'd3,0,0,2'd0,2'd0,0);
  localparam logic [19:0] E_WB_R       = mk(0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1,2'd1,2'd0,0);
  localparam logic [19:0] E_EXEC_I     = mk(0,0,0,0,0,0,2'd0,1,2'd2,2'd2,0,0,2'd0,2'd0,0);
  localparam logic [19:0] E_WB_I       = mk(0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1,2'd0,2'd0,0);
  localparam logic [19:0] E_ADDR       = mk(0,0,0,0,0,0,2'd0,1,2'd2,2'd0,1,0,2'd0,2'd0,0);
  localparam logic [19:0] E_MEM_RD     = mk(1,0,1,0,0,0,2'd0,0,2'd0,2'd0,0,0,2'd0,2'd0,0);
  localparam logic [19:0] E_WB_MEM     = mk(0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1,2'd0,2'd1,0);
  localparam logic [19:0] E_MEM_WR     = mk(1,1,1,0,0,0,2'd0,0,2'd0,2'd0,0,0,2'd0,2'd0,0);
  localparam logic [19:0] E_BRANCH     = mk(0,0,0,0,0,1,2'd1,1,2'd0,2'd1,0,0,2'd0,2'd0,0);
  localparam logic [19:0] E_JUMP       = mk(0,0,0,0,1,0,2'd2,0,2'd0,2'd0,0,1,2'd2,2'd2,0);
  localparam logic [19:0] E_TRAP       = mk(0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,2'd0,2'd0,1);

  logic [19:0] exp_q[$];
  string       tag_q[$];
  int          checks   = 0;
  int          failures = 0;

  wire [19:0] got = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                     alu_src_a, alu_src_b, alu_op, extend_op, reg_write, reg_dst,
                     mem_to_reg, illegal};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got=%05h expected=%05h", t, got, e);
      end
    end
  end

  task automatic step(input logic r, input logic [5:0] o, input logic z,
                      input logic a, input logic [19:0] e, input string t);
    rst = r; op = o; zero = z; mem_ack = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; op = 6'd0; zero = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;

    // Reset state, ack ignored while idle, FETCH one clock after release.
    step(1, 6'h00, 0, 1, E_ZERO, "rst_hold");
    step(1, 6'h00, 0, 1, E_ZERO, "rst_hold_ack");
    step(0, 6'h00, 0, 0, E_ZERO, "idle_after_rst");
    step(0, 6'h00, 0, 0, E_FETCH_WAIT, "fetch_wait");
    // Async reset in the middle of a held fetch.
    step(1, 6'h00, 0, 0, E_ZERO, "rst_mid_fetch");
    step(1, 6'h00, 0, 0, E_ZERO, "rst_mid_fetch_hold");
    step(0, 6'h00, 0, 0, E_ZERO, "idle_release");
    $display("txn reset_mid_fetch done");

    // R-type with ack tied high: 4 cycles.
    step(0, 6'b000000, 0, 1, E_FETCH_ACK, "r_fetch");
    step(0, 6'b000000, 0, 1, E_DECODE, "r_decode");
    step(0, 6'b000000, 0, 1, E_EXEC_R, "r_exec");
    step(0, 6'b000000, 0, 1, E_WB_R, "r_wb");
    $display("txn rtype done");

    // LW: 2 fetch waits, 3 read waits, 10 cycles total.
    step(0, 6'b100011, 0, 0, E_FETCH_WAIT, "lw_fetch_w1");
    step(0, 6'b100011, 0, 0, E_FETCH_WAIT, "lw_fetch_w2");
    step(0, 6'b100011, 0, 1, E_FETCH_ACK, "lw_fetch_ack");
    step(0, 6'b100011, 0, 1, E_DECODE, "lw_decode");
    step(0, 6'b100011, 0, 1, E_ADDR, "lw_addr");
    step(0, 6'b100011, 0, 0, E_MEM_RD, "lw_rd_w1");
    step(0, 6'b100011, 0, 0, E_MEM_RD, "lw_rd_w2");
    step(0, 6'b100011, 0, 0, E_MEM_RD, "lw_rd_w3");
    step(0, 6'b100011, 0, 1, E_MEM_RD, "lw_rd_ack");
    step(0, 6'b100011, 0, 0, E_WB_MEM, "lw_wb");
    $display("txn lw done");

    // SW with one write wait.
    step(0, 6'b101011, 0, 1, E_FETCH_ACK, "sw_fetch");
    step(0, 6'b101011, 0, 0, E_DECODE, "sw_decode");
    step(0, 6'b101011, 0, 0, E_ADDR, "sw_addr");
    step(0, 6'b101011, 0, 0, E_MEM_WR, "sw_wr_w1");
    step(0, 6'b101011, 0, 1, E_MEM_WR, "sw_wr_ack");
    $display("txn sw done");

    // ORI.
    step(0, 6'b001101, 0, 1, E_FETCH_ACK, "ori_fetch");
    step(0, 6'b001101, 0, 1, E_DECODE, "ori_decode");
    step(0, 6'b001101, 0, 1, E_EXEC_I, "ori_exec");
    step(0, 6'b001101, 0, 1, E_WB_I, "ori_wb");
    $display("txn ori done");

    // BEQ taken and not taken: identical control, 3 cycles each.
    step(0, 6'b000100, 1, 1, E_FETCH_ACK, "beq1_fetch");
    step(0, 6'b000100, 1, 1, E_DECODE, "beq1_decode");
    step(0, 6'b000100, 1, 1, E_BRANCH, "beq1_branch");
    step(0, 6'b000100, 0, 1, E_FETCH_ACK, "beq0_fetch");
    step(0, 6'b000100, 0, 1, E_DECODE, "beq0_decode");
    step(0, 6'b000100, 0, 1, E_BRANCH, "beq0_branch");
    $display("txn beq done");

    // JAL.
    step(0, 6'b000011, 0, 1, E_FETCH_ACK, "jal_fetch");
    step(0, 6'b000011, 0, 1, E_DECODE, "jal_decode");
    step(0, 6'b000011, 0, 1, E_JUMP, "jal_jump");
    $display("txn jal done");

    // Illegal opcode: TRAP is sticky and ignores memory activity until reset.
    step(0, 6'b111111, 0, 1, E_FETCH_ACK, "bad_fetch");
    step(0, 6'b111111, 0, 1, E_DECODE, "bad_decode");
    for (int i = 0; i < 20; i++) step(0, 6'b111111, 0, 1'(i % 2), E_TRAP, "trap_hold");
    step(1, 6'b111111, 0, 0, E_ZERO, "trap_rst");
    step(0, 6'b111111, 0, 0, E_ZERO, "trap_idle");
    step(0, 6'b111111, 0, 0, E_FETCH_WAIT, "trap_refetch");
    $display("txn trap done");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
